// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: round-robin sharing of one 1RW SRAM port between two requesters, with optional zero-fill after reset.
module sram_1rw_arbiter #(
    parameter int DATA_WIDTH    = 2,
    parameter int ADDR_WIDTH    = 4,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  reqA_valid,
    output logic                  reqA_ready,
    input  logic                  reqA_we,
    input  logic [ADDR_WIDTH-1:0] reqA_addr,
    input  logic [DATA_WIDTH-1:0] reqA_din,
    output logic                  rspA_valid,
    output logic [DATA_WIDTH-1:0] rspA_dout,
    input  logic                  reqB_valid,
    output logic                  reqB_ready,
    input  logic                  reqB_we,
    input  logic [ADDR_WIDTH-1:0] reqB_addr,
    input  logic [DATA_WIDTH-1:0] reqB_din,
    output logic                  rspB_valid,
    output logic [DATA_WIDTH-1:0] rspB_dout,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] ADDR0,
    output logic [DATA_WIDTH-1:0] DIN0,
    input  logic [DATA_WIDTH-1:0] DOUT0,
    output logic                  init_done
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, iss_addr;
    logic [DATA_WIDTH-1:0] iss_din;
    logic ptr, run, iss, iss_we;
    logic t1_v, t1_p, t1_r, t2_v, t2_p, t2_r;

    always_ff @(posedge clk0) begin
        if (rst0) state <= (INIT_ON_RESET != 0) ? INIT : RUN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = (state == INIT && cnt == '1) ? RUN : state;
    end

    // ptr holds the last grant (1 = B), so a tie goes to the other side
    always_comb begin
        run        = state == RUN && !rst0;
        reqA_ready = run & reqA_valid & (~reqB_valid | ptr);
        reqB_ready = run & reqB_valid & (~reqA_valid | ~ptr);
        iss        = state == INIT || reqA_ready || reqB_ready;
        iss_we     = state == INIT || (reqA_ready ? reqA_we : reqB_we);
        iss_addr   = state == INIT ? cnt : reqA_ready ? reqA_addr : reqB_addr;
        iss_din    = state == INIT ? '0 : reqA_ready ? reqA_din : reqB_din;
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            csb0       <= 1'b1;
            web0       <= 1'b1;
            ADDR0      <= '0;
            DIN0       <= '0;
            cnt        <= '0;
            ptr        <= 1'b1;
            {t1_v, t1_p, t1_r, t2_v, t2_p, t2_r} <= '0;
            rspA_valid <= 1'b0;
            rspB_valid <= 1'b0;
            rspA_dout  <= '0;
            rspB_dout  <= '0;
            init_done  <= 1'b0;
        end else begin
            csb0 <= ~iss;
            web0 <= ~(iss & iss_we);
            if (iss) begin
                ADDR0 <= iss_addr;
                DIN0  <= iss_din;
            end
            if (state == INIT) cnt <= cnt + 1'b1;
            if (reqA_ready | reqB_ready) ptr <= reqB_ready;
            // tag stage 1 aligns with the SRAM access, stage 2 with DOUT0
            t1_v <= reqA_ready | reqB_ready;
            t1_p <= reqB_ready;
            t1_r <= reqA_ready ? ~reqA_we : ~reqB_we;
            {t2_v, t2_p, t2_r} <= {t1_v, t1_p, t1_r};
            rspA_valid <= t2_v & t2_r & ~t2_p;
            rspB_valid <= t2_v & t2_r & t2_p;
            if (t2_v & t2_r & ~t2_p) rspA_dout <= DOUT0;
            if (t2_v & t2_r & t2_p) rspB_dout <= DOUT0;
            init_done <= state == RUN;
        end
    end
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// tb_sram_1rw_arbiter: directed checks of the arbiter against a behavioural 2x16 SRAM.
module tb_sram_1rw_arbiter;
    logic clk0 = 1'b0, rst0;
    logic reqA_valid, reqA_ready, reqA_we, rspA_valid;
    logic reqB_valid, reqB_ready, reqB_we, rspB_valid;
    logic [3:0] reqA_addr, reqB_addr, ADDR0;
    logic [1:0] reqA_din, reqB_din, rspA_dout, rspB_dout, DIN0, DOUT0;
    logic csb0, web0, init_done;
    logic [1:0] mem [16];
    int checks = 0, errors = 0;

    typedef struct {
        logic av, aw; logic [3:0] aa; logic [1:0] ad;
        logic bv, bw; logic [3:0] ba; logic [1:0] bd;
        logic rdy_a, rdy_b, csb, web; logic [3:0] addr; logic [1:0] din;
    } vec_t;
    vec_t tv [9];

    sram_1rw_arbiter dut (
        .clk0(clk0), .rst0(rst0),
        .reqA_valid(reqA_valid), .reqA_ready(reqA_ready), .reqA_we(reqA_we),
        .reqA_addr(reqA_addr), .reqA_din(reqA_din), .rspA_valid(rspA_valid), .rspA_dout(rspA_dout),
        .reqB_valid(reqB_valid), .reqB_ready(reqB_ready), .reqB_we(reqB_we),
        .reqB_addr(reqB_addr), .reqB_din(reqB_din), .rspB_valid(rspB_valid), .rspB_dout(rspB_dout),
        .csb0(csb0), .web0(web0), .ADDR0(ADDR0), .DIN0(DIN0), .DOUT0(DOUT0), .init_done(init_done)
    );

    always #5 clk0 = ~clk0;

    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) mem[ADDR0] <= DIN0;
            else DOUT0 <= mem[ADDR0];
        end
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        reqA_valid = 0; reqB_valid = 0; reqA_we = 0; reqB_we = 0;
        reqA_addr = 0; reqB_addr = 0; reqA_din = 0; reqB_din = 0;
    endtask

    task automatic drive_a(input logic we, input logic [3:0] a, input logic [1:0] d);
        reqA_valid = 1; reqA_we = we; reqA_addr = a; reqA_din = d;
    endtask

    task automatic drive_b(input logic we, input logic [3:0] a, input logic [1:0] d);
        reqB_valid = 1; reqB_we = we; reqB_addr = a; reqB_din = d;
    endtask

    initial begin
        tv[0] = '{1,1,4'hC,2'b01, 0,0,4'h0,2'b00, 1,0, 0,0,4'hC,2'b01};
        tv[1] = '{0,0,4'h0,2'b00, 1,1,4'hA,2'b11, 0,1, 0,0,4'hA,2'b11};
        tv[2] = '{1,1,4'h3,2'b10, 1,1,4'h4,2'b01, 1,0, 0,0,4'h3,2'b10};
        tv[3] = '{1,1,4'h3,2'b10, 1,1,4'h4,2'b01, 0,1, 0,0,4'h4,2'b01};
        tv[4] = '{0,0,4'h0,2'b00, 0,0,4'h0,2'b00, 0,0, 1,1,4'h4,2'b01};
        tv[5] = '{0,0,4'h0,2'b00, 1,1,4'h5,2'b10, 0,1, 0,0,4'h5,2'b10};
        tv[6] = '{1,1,4'h6,2'b00, 1,1,4'h7,2'b11, 1,0, 0,0,4'h6,2'b00};
        tv[7] = '{1,1,4'h6,2'b00, 1,1,4'h7,2'b11, 0,1, 0,0,4'h7,2'b11};
        tv[8] = '{0,0,4'h0,2'b00, 0,0,4'h0,2'b00, 0,0, 1,1,4'h7,2'b11};

        idle();
        rst0 = 1;
        tick(); tick();
        reqA_valid = 1; reqB_valid = 1;
        #1;
        chk("rst_ready_a", reqA_ready, 0);
        chk("rst_ready_b", reqB_ready, 0);
        chk("rst_csb0", csb0, 1);
        chk("rst_web0", web0, 1);
        chk("rst_addr0", ADDR0, 0);
        chk("rst_din0", DIN0, 0);
        chk("rst_rsp", {rspA_valid, rspB_valid, rspA_dout, rspB_dout}, 0);
        chk("rst_init_done", init_done, 0);
        rst0 = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 15) begin
                chk("init_ready_a", reqA_ready, 0);
                chk("init_ready_b", reqB_ready, 0);
            end
            tick();
            if (i == 15) idle();
            chk("init_csb0", csb0, 0);
            chk("init_web0", web0, 0);
            chk("init_addr0", ADDR0, i);
            chk("init_din0", DIN0, 0);
            chk("init_done_low", init_done, 0);
        end
        tick();
        chk("init_done_17", init_done, 1);
        chk("init_end_csb0", csb0, 1);

        for (int i = 0; i < 9; i++) begin
            idle();
            if (tv[i].av) drive_a(tv[i].aw, tv[i].aa, tv[i].ad);
            if (tv[i].bv) drive_b(tv[i].bw, tv[i].ba, tv[i].bd);
            #1;
            chk($sformatf("vec%0d_ready_a", i), reqA_ready, tv[i].rdy_a);
            chk($sformatf("vec%0d_ready_b", i), reqB_ready, tv[i].rdy_b);
            tick();
            chk($sformatf("vec%0d_csb0", i), csb0, tv[i].csb);
            chk($sformatf("vec%0d_web0", i), web0, tv[i].web);
            chk($sformatf("vec%0d_addr0", i), ADDR0, tv[i].addr);
            chk($sformatf("vec%0d_din0", i), DIN0, tv[i].din);
        end
        idle();

        for (int k = 0; k < 8; k++) begin
            idle();
            if (k < 4) begin
                drive_a(0, 4'hC, 2'b00);
                drive_b(0, 4'hA, 2'b00);
                #1;
                chk("cont_ready_a", reqA_ready, k % 2 == 0);
                chk("cont_ready_b", reqB_ready, k % 2 == 1);
            end
            tick();
            chk("cont_rsp_a", rspA_valid, k == 2 || k == 4);
            chk("cont_rsp_b", rspB_valid, k == 3 || k == 5);
            if (k == 2 || k == 4) chk("cont_dout_a", rspA_dout, 2'b01);
            if (k == 3 || k == 5) chk("cont_dout_b", rspB_dout, 2'b11);
        end

        drive_a(1, 4'h1, 2'b10);
        #1;
        chk("sp_wr_ready", reqA_ready, 1);
        tick();
        drive_a(0, 4'h1, 2'b00);
        tick();
        idle();
        chk("sp_rd_csb0", csb0, 0);
        chk("sp_rd_web0", web0, 1);
        chk("sp_rd_addr0", ADDR0, 4'h1);
        tick();
        chk("sp_rsp_early", rspA_valid, 0);
        tick();
        chk("sp_rsp_a", rspA_valid, 1);
        chk("sp_dout_a", rspA_dout, 2'b10);
        chk("sp_rsp_b", rspB_valid, 0);
        tick();
        chk("sp_rsp_width", rspA_valid, 0);
        chk("sp_dout_hold", rspA_dout, 2'b10);

        drive_a(1, 4'hA, 2'b00);
        tick();
        idle();
        drive_b(1, 4'hA, 2'b11);
        tick();
        idle();
        drive_a(0, 4'hA, 2'b00);
        tick();
        idle();
        tick();
        chk("wr_rd_early", rspA_valid, 0);
        tick();
        chk("wr_rd_rsp", rspA_valid, 1);
        chk("wr_rd_dout", rspA_dout, 2'b11);

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_csb0", csb0, 1);
            chk("idle_web0", web0, 1);
        end

        drive_a(0, 4'h1, 2'b00);
        tick();
        idle();
        rst0 = 1;
        reqB_valid = 1;
        #1;
        chk("mid_rst_ready_b", reqB_ready, 0);
        tick();
        idle();
        rst0 = 0;
        chk("mid_rst_rsp", rspA_valid, 0);
        chk("mid_rst_init_done", init_done, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_rsp", {rspA_valid, rspB_valid}, 0);
            chk("reinit_addr0", ADDR0, i);
            chk("reinit_web0", web0, 0);
        end
        for (int i = 0; i < 30 && !init_done; i++) tick();
        chk("reinit_done", init_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_1rw_arbiter.md
SRAM_1RW_ARBITER -- requirements
Module: sram_1rw_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 2, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width; depth is 2^ADDR_WIDTH.
- INIT_ON_RESET, 1, when 1, zero-fill every SRAM word after reset.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk0, in, 1, the one clock; all logic on rising edge.
- rst0, in, 1, reset, synchronous, active-high.
- reqA_valid, in, 1, requester A command valid.
- reqA_ready, out, 1, requester A command accepted this cycle.
- reqA_we, in, 1, 1=write, 0=read.
- reqA_addr, in, ADDR_WIDTH, address.
- reqA_din, in, DATA_WIDTH, write data.
- rspA_valid, out, 1, one-cycle read-data pulse.
- rspA_dout, out, DATA_WIDTH, read data.
- reqB_* / rspB_*, same as A, requester B.
- csb0, out, 1, SRAM chip select, active-low, registered.
- web0, out, 1, SRAM write enable, active-low, registered.
- ADDR0, out, ADDR_WIDTH, SRAM address, registered.
- DIN0, out, DATA_WIDTH, SRAM write data, registered.
- DOUT0, in, DATA_WIDTH, SRAM read data; valid one cycle after the SRAM samples a read.
- init_done, out, 1, high once the INIT sweep has finished.

Function
REQ-003 The FSM SHALL have the states INIT and RUN.
- Reset enters INIT if INIT_ON_RESET=1, else RUN.
REQ-004 INIT SHALL behave as follows.
- Issue one write of 0 per cycle to addresses 0 .. 2^ADDR_WIDTH-1 in ascending order.
- Both ready outputs are held 0.
- After the last address is issued, go to RUN and set init_done=1 in the following cycle.
REQ-005 In RUN, at most one command SHALL be accepted per cycle.
- Accept = reqX_valid & reqX_ready at a rising edge.
- readyX is combinational from the valids and the priority pointer only, never from the other ready.
REQ-006 Arbitration SHALL be round-robin with a 1-bit last-grant pointer.
- If only one requester is valid, it is granted.
- If both are valid, the requester not granted last is granted.
- Pointer reset value selects A first.
- The pointer updates only on an accept.
REQ-007 An accepted command SHALL drive csb0=0 in the next cycle.
- Also in that cycle: web0=~we, and ADDR0/DIN0 = the command fields.
- In cycles with no accept, csb0=1 and web0=1, and ADDR0/DIN0 hold their previous values.
REQ-008 Read latency SHALL be 2 cycles from the accept edge.
- DOUT0 is registered at edge N+2 into rspX_dout, with rspX_valid=1 for exactly the cycle after edge N+2, X being the accepting requester.
REQ-009 Writes SHALL produce no response pulse.
REQ-010 Back-to-back accepts SHALL be supported every cycle with no bubbles.
- A 2-entry tag pipeline (valid, port, is_read) tracks the commands in flight.
REQ-011 Ordering SHALL be as follows.
- A read issued after a write to the same address returns the new data.
- Commands reach the SRAM in acceptance order.
REQ-012 rspX_dout SHALL hold its last value when rspX_valid=0.
REQ-013 rspA_valid and rspB_valid SHALL never be high in the same cycle.

Reset
REQ-014 While rst0=1 at a rising edge, the following registers SHALL be cleared.
- Outputs: csb0=1, web0=1, ADDR0=0, DIN0=0, rspA/B_valid=0, rspA/B_dout=0, init_done=0.
- Internal: INIT address counter=0, pipeline tags invalid, pointer=A.
REQ-015 Reset asserted mid-INIT or mid-traffic SHALL behave as follows.
- In-flight reads are discarded and produce no response.
- The INIT sweep restarts from address 0.
REQ-016 reqA_ready and reqB_ready SHALL be 0 in any cycle where rst0=1.

Verification
REQ-017 The bench SHALL cover at least these scenarios, with a behavioural 2x16 SRAM model attached.
- INIT sweep: reset with INIT_ON_RESET=1 -> 16 consecutive writes of 0 to addresses 0..15; init_done=1 exactly 17 cycles after reset release; ready=0 throughout.
- Single-port traffic: A writes 2'b10 to address 1, then A reads address 1 -> rspA_valid one cycle wide, 2 cycles after the read accept, with rspA_dout=2'b10; rspB_valid stays 0.
- Contention: A and B both valid for 4 cycles, A reading address 0xC (preloaded 2'b01) and B reading address 0xA (2'b11) -> grants in order A,B,A,B; responses alternate 01,11,01,11.
- Write then read, same address: B writes 2'b11 to address 0xA on cycle N, A reads address 0xA on cycle N+1 -> rspA_dout=2'b11.
- Reset during a read in flight: rst0 asserted one cycle after the accept -> no rsp pulse; INIT restarts from address 0.
- Idle: no valids for 10 cycles in RUN -> csb0=1 and web0=1 every cycle.
